line_buffer_generic: RTL and testbench

- Parametrised multi-line buffer; next generation of the team's single-port RAM block.
- Sits between the pixel stream source and the sliding-window kernels (e.g. Gaussian filter).
- Accepts one raster-order pixel per valid cycle and emits a vertical column of LINES+1 pixels: the current pixel plus the same column from the previous LINES rows.
- Stores history in one inferred memory of IMG_WIDTH entries x LINES*DATA_BITS, using a read-then-delayed-write scheme.

---
 rtl/line_buffer_generic.sv | 97 +++++++++
 tb/tb_line_buffer_generic.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_generic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// line_buffer_generic - raster line buffer emitting a LINES+1 pixel column
// Revision: 1.0
// ============================================================================
module line_buffer_generic #(
  parameter int DATA_BITS = 8,
  parameter int IMG_WIDTH = 640,
  parameter int ADDR_BITS = 10,
  parameter int LINES     = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             din_vld,
  input  logic                             din_sof,
  input  logic [DATA_BITS-1:0]             din,
  output logic                             dout_vld,
  output logic [(LINES+1)*DATA_BITS-1:0]   dout,
  output logic [ADDR_BITS-1:0]             dout_col,
  output logic                             dout_full
);

  localparam int                  MEM_BITS = LINES * DATA_BITS;
  localparam int                  ROW_BITS = $clog2(LINES + 1);
  localparam logic [ADDR_BITS-1:0] LAST_COL = ADDR_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0]  ROW_FULL = ROW_BITS'(LINES);

  logic [MEM_BITS-1:0]              mem_q [IMG_WIDTH];
  logic [MEM_BITS-1:0]              rd_data;

  logic [ADDR_BITS-1:0]             col_q, col_d;
  logic [ROW_BITS-1:0]              row_cnt_q, row_cnt_d;
  logic [ADDR_BITS-1:0]             ec;
  logic [ROW_BITS-1:0]              row_eff;

  logic                             vld_q, vld_d;
  logic [(LINES+1)*DATA_BITS-1:0]   dout_q, dout_d;
  logic [ADDR_BITS-1:0]             dout_col_q, dout_col_d;
  logic                             full_q, full_d;

  // Asynchronous read in stage 0; the stage-1 write never targets this address.
  assign rd_data = mem_q[ec];

  always_comb begin
    ec         = din_sof ? '0 : col_q;
    row_eff    = din_sof ? '0 : row_cnt_q;
    col_d      = col_q;
    row_cnt_d  = row_cnt_q;
    vld_d      = din_vld;
    dout_d     = dout_q;
    dout_col_d = dout_col_q;
    full_d     = full_q;
    if (din_vld) begin
      col_d      = (ec == LAST_COL) ? '0 : ec + 1'b1;
      row_cnt_d  = row_eff;
      if ((ec == LAST_COL) && (row_eff != ROW_FULL)) begin
        row_cnt_d = row_eff + 1'b1;
      end
      dout_d     = {rd_data, din};
      dout_col_d = ec;
      full_d     = (row_eff == ROW_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_cnt_q  <= '0;
      vld_q      <= 1'b0;
      dout_q     <= '0;
      dout_col_q <= '0;
      full_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_cnt_q  <= row_cnt_d;
      vld_q      <= vld_d;
      dout_q     <= dout_d;
      dout_col_q <= dout_col_d;
      full_q     <= full_d;
    end
  end

  // Shift the column down one row: oldest slice falls off the top.
  always_ff @(posedge clk) begin
    if (vld_q) begin
      mem_q[dout_col_q] <= dout_q[MEM_BITS-1:0];
    end
  end

  assign dout_vld  = vld_q;
  assign dout      = dout_q;
  assign dout_col  = dout_col_q;
  assign dout_full = full_q;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_generic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_line_buffer_generic - scoreboard bench for two line buffer configurations
// Revision: 1.0
// ============================================================================
module tb_line_buffer_generic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vld0, sof0;
  logic [7:0]  din0;
  logic        dvld0, dfull0;
  logic [23:0] dout0;
  logic [1:0]  dcol0;
  logic        vld1, sof1;
  logic [7:0]  din1;
  logic        dvld1, dfull1;
  logic [15:0] dout1;
  logic [0:0]  dcol1;

  line_buffer_generic #(.DATA_BITS(8), .IMG_WIDTH(4), .ADDR_BITS(2), .LINES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din_vld(vld0), .din_sof(sof0), .din(din0),
    .dout_vld(dvld0), .dout(dout0), .dout_col(dcol0), .dout_full(dfull0));

  line_buffer_generic #(.DATA_BITS(8), .IMG_WIDTH(2), .ADDR_BITS(1), .LINES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din_vld(vld1), .din_sof(sof1), .din(din1),
    .dout_vld(dvld1), .dout(dout1), .dout_col(dcol1), .dout_full(dfull1));

  typedef struct {
    logic [23:0] d;
    logic [23:0] m;
    logic [1:0]  col;
    logic        full;
    int          t;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t last0, last1, mon0_e, mon1_e;

  logic [7:0] h0 [4][2];
  bit         k0 [4][2];
  int         mcol0, mrow0;
  logic [7:0] h1 [2];
  bit         k1 [2];
  int         mcol1, mrow1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] p, input logic sof);
    exp_t e;
    int   ec, r;
    ec     = sof ? 0 : mcol0;
    r      = sof ? 0 : mrow0;
    e.d    = {h0[ec][1], h0[ec][0], p};
    e.m    = {k0[ec][1] ? 8'hFF : 8'h00, k0[ec][0] ? 8'hFF : 8'h00, 8'hFF};
    e.col  = 2'(ec);
    e.full = (r == 2);
    e.t    = cyc + 1;
    h0[ec][1] = h0[ec][0];
    k0[ec][1] = k0[ec][0];
    h0[ec][0] = p;
    k0[ec][0] = 1'b1;
    if (ec == 3) begin
      mcol0 = 0;
      if (r < 2) r++;
    end else begin
      mcol0 = ec + 1;
    end
    mrow0 = r;
    q0.push_back(e);
    vld0 = 1'b1; sof0 = sof; din0 = p;
    @(negedge clk);
    vld0 = 1'b0; sof0 = 1'b0;
  endtask

  task automatic send1(input logic [7:0] p, input logic sof);
    exp_t e;
    int   ec, r;
    ec     = sof ? 0 : mcol1;
    r      = sof ? 0 : mrow1;
    e.d    = {8'h00, h1[ec], p};
    e.m    = {8'h00, k1[ec] ? 8'hFF : 8'h00, 8'hFF};
    e.col  = 2'(ec);
    e.full = (r == 1);
    e.t    = cyc + 1;
    h1[ec] = p;
    k1[ec] = 1'b1;
    if (ec == 1) begin
      mcol1 = 0;
      r     = 1;
    end else begin
      mcol1 = ec + 1;
    end
    mrow1 = r;
    q1.push_back(e);
    vld1 = 1'b1; sof1 = sof; din1 = p;
    @(negedge clk);
    vld1 = 1'b0; sof1 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dvld0) begin
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL dut0_extra: dout_vld with nothing expected, dout=%h col=%0d", dout0, dcol0);
        end else begin
          mon0_e = q0.pop_front();
          last0  = mon0_e;
          if ((((dout0 ^ mon0_e.d) & mon0_e.m) != 0) || (dcol0 != mon0_e.col) ||
              (dfull0 != mon0_e.full) || (cyc != mon0_e.t)) begin
            errors++;
            $display("FAIL dut0_out: got dout=%h col=%0d full=%0d cyc=%0d, expected dout=%h mask=%h col=%0d full=%0d cyc=%0d",
                     dout0, dcol0, dfull0, cyc, mon0_e.d, mon0_e.m, mon0_e.col, mon0_e.full, mon0_e.t);
          end
        end
      end else if ((((dout0 ^ last0.d) & last0.m) != 0) || (dcol0 != last0.col)) begin
        errors++;
        $display("FAIL dut0_hold: got dout=%h col=%0d, expected dout=%h mask=%h col=%0d",
                 dout0, dcol0, last0.d, last0.m, last0.col);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dvld1) begin
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL dut1_extra: dout_vld with nothing expected, dout=%h col=%0d", dout1, dcol1);
        end else begin
          mon1_e = q1.pop_front();
          last1  = mon1_e;
          if (((({8'h00, dout1}) ^ mon1_e.d) & mon1_e.m) != 0 || ({1'b0, dcol1} != mon1_e.col) ||
              (dfull1 != mon1_e.full) || (cyc != mon1_e.t)) begin
            errors++;
            $display("FAIL dut1_out: got dout=%h col=%0d full=%0d cyc=%0d, expected dout=%h mask=%h col=%0d full=%0d cyc=%0d",
                     dout1, dcol1, dfull1, cyc, mon1_e.d, mon1_e.m, mon1_e.col, mon1_e.full, mon1_e.t);
          end
        end
      end else if (((({8'h00, dout1}) ^ last1.d) & last1.m) != 0 || ({1'b0, dcol1} != last1.col)) begin
        errors++;
        $display("FAIL dut1_hold: got dout=%h col=%0d, expected dout=%h mask=%h col=%0d",
                 dout1, dcol1, last1.d, last1.m, last1.col);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    vld0 = 1'b0; sof0 = 1'b0; din0 = '0;
    vld1 = 1'b0; sof1 = 1'b0; din1 = '0;
    mcol0 = 0; mrow0 = 0; mcol1 = 0; mrow1 = 0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        h0[c][k] = '0;
        k0[c][k] = 1'b0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      h1[c] = '0;
      k1[c] = 1'b0;
    end
    last0 = '{d: 24'h0, m: 24'hFFFFFF, col: 2'd0, full: 1'b0, t: 0};
    last1 = '{d: 24'h0, m: 24'h00FFFF, col: 2'd0, full: 1'b0, t: 0};

    idle(2);
    chk("reset_vld0",  32'(dvld0),  32'd0);
    chk("reset_dout0", 32'(dout0),  32'd0);
    chk("reset_col0",  32'(dcol0),  32'd0);
    chk("reset_full0", 32'(dfull0), 32'd0);
    chk("reset_vld1",  32'(dvld1),  32'd0);
    chk("reset_dout1", 32'(dout1),  32'd0);
    rst_n = 1'b1;
    idle(1);

    // Two-pixel-wide single history line: each column against its previous row.
    for (int i = 0; i < 8; i++) begin
      send1(8'(8'hA0 + i), i == 0);
      if (i == 3) begin
        chk("w2_dout", 32'(dout1),  32'h0000A1A3);
        chk("w2_col",  32'(dcol1),  32'd1);
        chk("w2_full", 32'(dfull1), 32'd1);
      end
    end
    idle(2);

    // Continuous fill, rows 0-2.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        send0(8'(16 * r + c), (r == 0) && (c == 0));
        if (r == 1 && c == 2) chk("fill_r1_full", 32'(dfull0), 32'd0);
        if (r == 2 && c == 1) begin
          chk("fill_r2c1_dout", 32'(dout0),  32'h00011121);
          chk("fill_r2c1_col",  32'(dcol0),  32'd1);
          chk("fill_r2c1_full", 32'(dfull0), 32'd1);
        end
      end
    end
    idle(2);

    // Same frame with two idle cycles between accepted pixels.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        send0(8'(16 * r + c), (r == 0) && (c == 0));
        if (r == 2 && c == 1) chk("gap_r2c1_dout", 32'(dout0), 32'h00011121);
        idle(2);
      end
    end

    // Six rows: column wrap and row-counter saturation.
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) begin
        send0(8'(16 * r + c), (r == 0) && (c == 0));
        if (r == 5 && c == 3) begin
          chk("wrap_r5c3_dout", 32'(dout0),  32'h00334353);
          chk("wrap_r5c3_col",  32'(dcol0),  32'd3);
          chk("wrap_r5c3_full", 32'(dfull0), 32'd1);
        end
      end
    end
    idle(3);

    // Frame restarted by sof in the middle of row 3.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == 3 && c == 2) break;
        send0(8'(16 * r + c), (r == 0) && (c == 0));
      end
    end
    send0(8'h32, 1'b1);
    chk("midsof_col",  32'(dcol0),  32'd0);
    chk("midsof_full", 32'(dfull0), 32'd0);
    for (int i = 0; i < 11; i++) begin
      send0(8'(8'h90 + i), 1'b0);
      if (i == 6) chk("midsof_row1_full", 32'(dfull0), 32'd0);
      if (i == 7) chk("midsof_row2_full", 32'(dfull0), 32'd1);
    end

    // Reset with the last pixel's write still pending.
    send0(8'h9B, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld",  32'(dvld0),  32'd0);
    chk("midrst_dout", 32'(dout0),  32'd0);
    chk("midrst_full", 32'(dfull0), 32'd0);
    chk("midrst_col",  32'(dcol0),  32'd0);
    q0.delete();
    q1.delete();
    mcol0 = 0; mrow0 = 0; mcol1 = 0; mrow1 = 0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) k0[c][k] = 1'b0;
    end
    for (int c = 0; c < 2; c++) k1[c] = 1'b0;
    last0 = '{d: 24'h0, m: 24'hFFFFFF, col: 2'd0, full: 1'b0, t: 0};
    last1 = '{d: 24'h0, m: 24'h00FFFF, col: 2'd0, full: 1'b0, t: 0};
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 10; i++) begin
      send0(8'(8'hC0 + i), 1'b0);
      if (i == 0) chk("postrst_col0", 32'(dcol0),  32'd0);
      if (i == 7) chk("postrst_full", 32'(dfull0), 32'd0);
      if (i == 8) chk("postrst_fill", 32'(dfull0), 32'd1);
    end
    idle(3);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d outputs still owed, expected 0/0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
